// File: rtl/reg_file16_pkg.sv
// reg_file16_pkg: shared register-file geometry, also used by the 4-to-16 destination decoder.
package reg_file16_pkg;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 16;
    localparam int IDX_W    = 4;
endpackage

// File: rtl/reg_file16_onehot_check.sv
// onehot_check: flags a select word that has exactly one bit set.
module onehot_check
    import reg_file16_pkg::*;
(
    input  logic [NUM_REGS-1:0] sel,
    output logic                one_hot
);
    // x & (x-1) clears the lowest set bit; zero result with nonzero x means a single bit
    assign one_hot = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
endmodule

// File: rtl/reg_file16.sv
// reg_file16: 16-entry register file, one-hot write select, two bypassed read ports,
// sticky illegal-select flag and committed-write counter.
module reg_file16
    import reg_file16_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int NREGS = NUM_REGS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             regWrite,
    input  logic [15:0]      decOut,
    input  logic [WIDTH-1:0] writeData,
    input  logic [IDX_W-1:0] rs1,
    input  logic [IDX_W-1:0] rs2,
    output logic [WIDTH-1:0] readData1,
    output logic [WIDTH-1:0] readData2,
    output logic             wrErr,
    output logic [15:0]      wrCount
);
    logic [WIDTH-1:0] regs [NREGS];
    logic             legal;
    logic             commit;
    onehot_check u_check (.sel(decOut), .one_hot(legal));
    assign commit = regWrite && legal;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            wrErr   <= 1'b0;
            wrCount <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) if (commit && decOut[i]) regs[i] <= writeData;
            if (regWrite && !legal) wrErr <= 1'b1;
            if (commit) wrCount <= wrCount + 16'd1;
        end
    end
    // bypass is gated by reset so the read ports show zero while reset is held
    assign readData1 = (reset && commit && decOut[rs1]) ? writeData : regs[rs1];
    assign readData2 = (reset && commit && decOut[rs2]) ? writeData : regs[rs2];
endmodule

// File: tb/tb_reg_file16.sv
// tb_reg_file16: directed vectors against an array-based model of reg_file16,
// checked every negedge, plus literal expectations for the key scenarios.
module tb_reg_file16;
    logic        clk = 1'b0;
    logic        reset;
    logic        regWrite;
    logic [15:0] decOut;
    logic [15:0] writeData;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [15:0] readData1;
    logic [15:0] readData2;
    logic        wrErr;
    logic [15:0] wrCount;
    int checks = 0;
    int failures = 0;
    logic check_en = 1'b0;
    logic [15:0] m_regs [16] = '{default: 16'h0};
    logic        m_err = 1'b0;
    logic [15:0] m_cnt = 16'h0;

    reg_file16 dut (
        .clk(clk), .reset(reset), .regWrite(regWrite), .decOut(decOut),
        .writeData(writeData), .rs1(rs1), .rs2(rs2), .readData1(readData1),
        .readData2(readData2), .wrErr(wrErr), .wrCount(wrCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) m_regs[i] <= 16'h0;
            m_err <= 1'b0;
            m_cnt <= 16'h0;
        end else if (regWrite) begin
            if ($countones(decOut) == 1) begin
                for (int i = 0; i < 16; i++) if (decOut[i]) m_regs[i] <= writeData;
                m_cnt <= m_cnt + 16'd1;
            end else begin
                m_err <= 1'b1;
            end
        end
    end

    function automatic logic [15:0] exp_rd(input logic [3:0] idx);
        if (reset === 1'b1 && regWrite && $countones(decOut) == 1 && decOut[idx]) return writeData;
        if (reset !== 1'b1) return 16'h0;
        return m_regs[idx];
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_rd1", readData1, exp_rd(rs1));
            chk("model_rd2", readData2, exp_rd(rs2));
            chk("model_err", wrErr, m_err);
            chk("model_cnt", wrCount, m_cnt);
        end
    end

    task automatic apply(input logic rw, input logic [15:0] dec, input logic [15:0] wd,
                         input logic [3:0] a, input logic [3:0] b);
        regWrite = rw; decOut = dec; writeData = wd; rs1 = a; rs2 = b;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_sel();
        int k;
        k = $urandom_range(0, 5);
        if (k == 0) return 16'h0;
        if (k == 1) return (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
        return 16'h1 << $urandom_range(0, 15);
    endfunction

    initial begin
        reset = 1'b0; regWrite = 1'b0; decOut = 16'h0; writeData = 16'h0; rs1 = 4'h0; rs2 = 4'h0;
        check_en = 1'b1;
        for (int n = 0; n < 4; n++) begin
            apply(1'b1, 16'h1 << $urandom_range(0, 15), 16'($urandom), 4'($urandom), 4'($urandom));
            chk("reset_rd1", readData1, 16'h0);
            chk("reset_rd2", readData2, 16'h0);
            chk("reset_err", wrErr, 1'b0);
            chk("reset_cnt", wrCount, 16'h0);
            tick();
        end
        reset = 1'b1;
        // unqualified select of r15
        apply(1'b0, 16'h8000, 16'h5555, 4'd15, 4'd15);
        chk("noqual_rd1", readData1, 16'h0);
        tick();
        apply(1'b0, 16'h0, 16'h0, 4'd15, 4'd0);
        chk("noqual_r15", readData1, 16'h0);
        chk("noqual_err", wrErr, 1'b0);
        chk("noqual_cnt", wrCount, 16'h0);
        tick();
        // legal write with same-cycle bypass on both ports
        apply(1'b1, 16'h0008, 16'hBEEF, 4'd3, 4'd3);
        chk("byp_rd1", readData1, 16'hBEEF);
        chk("byp_rd2", readData2, 16'hBEEF);
        tick();
        apply(1'b0, 16'h0008, 16'h0000, 4'd3, 4'd2);
        chk("stored_rd1", readData1, 16'hBEEF);
        chk("stored_cnt", wrCount, 16'h0001);
        tick();
        apply(1'b1, 16'h0001, 16'h1111, 4'd0, 4'd4); tick();
        apply(1'b1, 16'h0010, 16'h4444, 4'd0, 4'd4); tick();
        // two-hot select: no write, no bypass, error set
        apply(1'b1, 16'h0011, 16'h1234, 4'd0, 4'd4);
        chk("ill_rd1", readData1, 16'h1111);
        chk("ill_rd2", readData2, 16'h4444);
        tick();
        apply(1'b0, 16'h0, 16'h0, 4'd0, 4'd4);
        chk("ill_r0", readData1, 16'h1111);
        chk("ill_r4", readData2, 16'h4444);
        chk("ill_err", wrErr, 1'b1);
        chk("ill_cnt", wrCount, 16'h0003);
        tick();
        apply(1'b1, 16'h0020, 16'h5A5A, 4'd5, 4'd0); tick();
        apply(1'b0, 16'h0, 16'h0, 4'd5, 4'd0);
        chk("sticky_err", wrErr, 1'b1);
        chk("sticky_cnt", wrCount, 16'h0004);
        chk("sticky_r5", readData1, 16'h5A5A);
        tick();
        for (int n = 0; n < 60; n++) begin
            apply($urandom_range(0, 3) != 0, rand_sel(), 16'($urandom), 4'($urandom), 4'($urandom));
            tick();
        end
        // reset asserted between edges clears state without a clock
        apply(1'b1, 16'h0080, 16'hA5A5, 4'd7, 4'd7); tick();
        apply(1'b0, 16'h0, 16'h0, 4'd7, 4'd7);
        chk("r7_written", readData1, 16'hA5A5);
        tick();
        #2 reset = 1'b0;
        #1;
        chk("async_rd1", readData1, 16'h0);
        chk("async_err", wrErr, 1'b0);
        chk("async_cnt", wrCount, 16'h0);
        tick();
        reset = 1'b1;
        for (int n = 0; n < 65536; n++) begin
            apply(1'b1, 16'h1 << $urandom_range(0, 15), 16'($urandom), 4'($urandom), 4'($urandom));
            tick();
            if (n == 65534) chk("cnt_max", wrCount, 16'hFFFF);
        end
        apply(1'b0, 16'h0, 16'h0, 4'd0, 4'd1);
        chk("wrap_cnt", wrCount, 16'h0000);
        chk("wrap_err", wrErr, 1'b0);
        tick();
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_file16.md
REG_FILE16 -- requirements
Module: reg_file16

Interface
REQ-001 SHALL have parameter: WIDTH, 16, data width of each register.
REQ-002 SHALL have parameter: NREGS, 16, number of registers; fixed to match the 16-bit one-hot write select.
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: regWrite  input  1  write qualifier from write-back stage.
REQ-006 SHALL have port: decOut  input  16  one-hot destination-register select from the 4-to-16 decoder.
REQ-007 SHALL have port: writeData  input  WIDTH  write-back data.
REQ-008 SHALL have port: rs1  input  4  read port 1 register index.
REQ-009 SHALL have port: rs2  input  4  read port 2 register index.
REQ-010 SHALL have port: readData1  output  WIDTH  contents of register rs1 (with bypass).
REQ-011 SHALL have port: readData2  output  WIDTH  contents of register rs2 (with bypass).
REQ-012 SHALL have port: wrErr  output  1  sticky flag: illegal write select seen.
REQ-013 SHALL have port: wrCount  output  16  count of committed writes.

Function
REQ-014 SHALL commit a write when regWrite=1 and decOut has exactly one bit set at a rising clk: register i <= writeData, where decOut[i]=1.
REQ-015 SHALL treat all 16 registers, including register 0, as writable general registers.
REQ-016 SHALL perform no register update when regWrite=0, regardless of decOut.
REQ-017 SHALL, when regWrite=1 and decOut is zero or has two or more bits set, write no register and set wrErr=1 at that edge.
REQ-018 SHALL hold wrErr=1 until reset; subsequent legal writes do not clear it.
REQ-019 SHALL increment wrCount by 1 on each committed write (REQ-014) only; illegal or unqualified cycles do not count.
REQ-020 SHALL wrap wrCount from 16'hFFFF to 16'h0000 without affecting wrErr.
REQ-021 SHALL drive readData1/readData2 combinationally from rs1/rs2 (zero-cycle read latency).
REQ-022 SHALL bypass: when a legal write is pending this cycle and decOut[rsN]=1, readDataN = writeData; otherwise the stored value.
REQ-023 SHALL apply bypass to both read ports independently, including rs1=rs2=write target.
REQ-024 SHALL never bypass on an illegal write select; read ports return stored values.
REQ-025 SHALL make a committed value visible without bypass from the cycle following the write edge.

Reset
REQ-026 SHALL, while reset=0, asynchronously force all registers, wrErr and wrCount to 0, independent of clk.
REQ-027 SHALL drive readData1/readData2 = 0 during reset (stored values zero, bypass suppressed).
REQ-028 SHALL discard any write coincident with reset assertion; the first write honoured is at the first rising clk with reset=1.
REQ-029 SHALL not require a clock edge for reset to take effect; reset mid-operation loses all stored state.

Structure
REQ-030 SHALL place WIDTH, NREGS and the register-index width (4) as constants in a shared package used with the decoder.
REQ-031 SHALL instantiate one sub-module, onehot_check, taking the 16-bit select and returning a 1-bit exactly-one-hot indication, used for commit, count, bypass and error decisions.
REQ-032 SHALL contain no other sub-modules; storage is a 16 x WIDTH register array in this module.

Verification
REQ-033 SHALL cover: reset low with random inputs -> readData1=readData2=0, wrErr=0, wrCount=0.
REQ-034 SHALL cover: regWrite=1, decOut=16'h0008, writeData=16'hBEEF, rs1=3 -> readData1=16'hBEEF same cycle (bypass); next cycle with regWrite=0, readData1=16'hBEEF, wrCount=1.
REQ-035 SHALL cover: regWrite=1, decOut=16'h0011, writeData=16'h1234 -> registers 0 and 4 unchanged, wrErr=1 after edge, wrCount unchanged, no bypass; legal write later leaves wrErr=1.
REQ-036 SHALL cover: regWrite=0, decOut=16'h8000, writeData=16'h5555 -> register 15 unchanged, wrErr=0, wrCount unchanged.
REQ-037 SHALL cover: 65536 legal writes from reset -> wrCount wraps to 16'h0000, wrErr=0.
REQ-038 SHALL cover: write 16'hA5A5 to register 7, assert reset mid-cycle between edges -> readData for rs1=7 goes to 0 immediately, before next clk.
